fifo_pipeline_sequencer: RTL and testbench
==========================================

// Module: fifo_pipeline_sequencer
// PURPOSE
//  Top-level sequencer for the UART receive -> FIFO -> output-consumer datapath.
//  Owns the COM_to_FIFO enable, the FIFO reset, the FIFO_to_out enable and the
//  isOutStart/isOutFinish consumer handshake. Runs one frame per start request:
//  flush, receive, drain byte-by-byte with a dwell per byte, then report done or error.
// PARAMETERS
//  HOLD_CYCLES     4      dwell cycles per drained byte before out_finish (>=1)
//  TIMEOUT_CYCLES  65535  no-progress limit in RECV/DRAIN (SEQ_TIMEOUT_EN only)
//  CNT_W           10     width of byte_count (matches FIFO count width)
// PORTS
//  clk              in   1      datapath clock (UART-rate clk); all logic on posedge
//  reset            in   1      asynchronous, active-high
//  start            in   1      single-cycle frame request (e.g. SinglePulser output)
//  abort            in   1      return to IDLE from any state
//  com_finish       in   1      COM_to_FIFO frame complete
//  com_error        in   4      COM_to_FIFO error code, 0 = ok
//  fifo_empty       in   1      FIFO empty flag
//  fifo_full        in   1      FIFO full flag
//  out_start        in   1      FIFO_to_out presents a byte
//  out_data         in   8      byte presented with out_start
//  out_ack          in   1      consumer early release of dwell
//  com_enable       out  1      enable COM_to_FIFO
//  fifo_reset       out  1      FIFO synchronous flush, 1-cycle pulse
//  fifo_to_out_en   out  1      enable FIFO_to_out
//  out_finish       out  1      1-cycle pulse: byte consumed
//  data_reg         out  8      last drained byte (display source)
//  byte_count       out  CNT_W  bytes drained this frame, saturating
//  busy / done      out  1      frame in progress / frame complete (level)
//  error            out  1      level, set in ERROR
//  error_code       out  4      latched cause
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE. Reset mid-operation drops every enable at once.
//  States: IDLE, FLUSH, RECV, CHECK, DRAIN, HOLD, FIN, DONE, ERROR (registered, Moore outputs).
//  IDLE: start -> FLUSH; clear byte_count, data_reg, error_code, done.
//  FLUSH: fifo_reset=1 exactly one cycle -> RECV.
//  RECV: com_enable=1. com_error!=0 -> ERROR, code=com_error (wins over com_finish same
//   cycle). fifo_full & !com_finish -> ERROR code 4'hF. com_finish -> CHECK.
//  CHECK: com_enable=0. fifo_empty -> DONE (zero-length frame) else DRAIN.
//  DRAIN: fifo_to_out_en=1. out_start -> latch out_data, byte_count+1 (saturate at
//   2^CNT_W-1), -> HOLD. fifo_empty & !out_start -> DONE.
//  HOLD: fifo_to_out_en=1; dwell counter counts 1..HOLD_CYCLES; at HOLD_CYCLES or out_ack
//   (whichever first) -> FIN. out_start ignored here.
//  FIN: out_finish=1 for this single cycle -> DRAIN.
//  Byte latency: out_start to out_finish = HOLD_CYCLES+1 cycles (2 with out_ack in first HOLD cycle).
//  DONE: done=1, busy=0; start -> FLUSH (new frame). ERROR: error=1, all enables 0;
//   only start (-> FLUSH) or abort leaves it.
//  busy=1 in FLUSH..FIN. start while busy ignored.
//  abort: highest priority after reset; next state IDLE, enables 0 same edge; pending
//   out_start same cycle is dropped (no latch, no count).
// CONFIGURATION
//  SEQ_TIMEOUT_EN defined: watchdog counter cleared on state entry, com_finish, and
//   out_start; increments in RECV and DRAIN; reaching TIMEOUT_CYCLES -> ERROR code 4'hE.
//   Not running in HOLD/FIN/DONE.
//  SEQ_TIMEOUT_EN undefined: no counter synthesised; RECV/DRAIN wait indefinitely;
//   code 4'hE never produced.
// TESTING
//  Reset asserted mid-DRAIN -> all outputs 0 same cycle, state IDLE after release.
//  start, com_finish after 3-byte frame 0x41,0x42,0x43 -> data_reg 0x41/0x42/0x43 in order,
//   out_finish 5 cycles after each out_start, byte_count=3, done=1.
//  start, com_finish with fifo_empty=1 -> DONE from CHECK, byte_count=0, no out_finish.
//  com_error=4'h2 with com_finish same cycle -> ERROR, error_code=2, com_enable=0 next cycle.
//  fifo_full in RECV -> error_code=4'hF; abort with out_start same cycle -> IDLE, byte_count unchanged.
//  SEQ_TIMEOUT_EN, TIMEOUT_CYCLES=16, silent RECV -> error_code=4'hE after 16 cycles; undefined -> stays RECV.

Source files
------------

// File: rtl/fifo_pipeline_sequencer.sv
// fifo_pipeline_sequencer: frame sequencer for UART rx -> FIFO -> consumer (flush, receive, drain with per-byte dwell)
// Optional no-progress watchdog in RECV/DRAIN: define SEQ_TIMEOUT_EN (raises error code 4'hE).
module fifo_pipeline_sequencer #(
   parameter int HOLD_CYCLES    = 4,
   parameter int TIMEOUT_CYCLES = 65535,
   parameter int CNT_W          = 10
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             abort,
   input  logic             com_finish,
   input  logic [3:0]       com_error,
   input  logic             fifo_empty,
   input  logic             fifo_full,
   input  logic             out_start,
   input  logic [7:0]       out_data,
   input  logic             out_ack,
   output logic             com_enable,
   output logic             fifo_reset,
   output logic             fifo_to_out_en,
   output logic             out_finish,
   output logic [7:0]       data_reg,
   output logic [CNT_W-1:0] byte_count,
   output logic             busy,
   output logic             done,
   output logic             error,
   output logic [3:0]       error_code
);
   typedef enum logic [3:0] {IDLE, FLUSH, RECV, CHECK, DRAIN, HOLD, FIN, DONE, ERROR} stateT;
   localparam int HW = $clog2(HOLD_CYCLES + 1);
   stateT state, nextState;
   logic [HW-1:0] holdCnt;
   logic [3:0] nextCode;
   logic toHit, newFrame, take;
`ifdef SEQ_TIMEOUT_EN
   localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
   logic [WW-1:0] wdCnt;
   always_ff @(posedge clk or posedge reset)
      if (reset) wdCnt <= '0;
      else if (nextState != state || com_finish || out_start) wdCnt <= '0;
      else if (state == RECV || state == DRAIN) wdCnt <= wdCnt + 1'b1;
   assign toHit = (state == RECV || state == DRAIN) && wdCnt == WW'(TIMEOUT_CYCLES - 1);
`else
   assign toHit = 1'b0 && (TIMEOUT_CYCLES != 0);
`endif
   always_comb begin
      nextState = state;
      nextCode = error_code;
      case (state)
         IDLE, DONE, ERROR: nextState = start ? FLUSH : state;
         FLUSH: nextState = RECV;
         RECV:
            if (com_error != 4'h0) begin
               nextState = ERROR;
               nextCode = com_error;
            end else if (fifo_full && !com_finish) begin
               nextState = ERROR;
               nextCode = 4'hF;
            end else if (com_finish) nextState = CHECK;
            else if (toHit) begin
               nextState = ERROR;
               nextCode = 4'hE;
            end
         CHECK: nextState = fifo_empty ? DONE : DRAIN;
         DRAIN:
            if (out_start) nextState = HOLD;
            else if (fifo_empty) nextState = DONE;
            else if (toHit) begin
               nextState = ERROR;
               nextCode = 4'hE;
            end
         HOLD: nextState = (holdCnt == HW'(HOLD_CYCLES) || out_ack) ? FIN : HOLD;
         FIN: nextState = DRAIN;
         default: nextState = IDLE;
      endcase
      if (abort) begin
         nextState = IDLE;
         nextCode = error_code;
      end
   end
   // FLUSH is only ever entered from a resting state, so it marks a new frame
   assign newFrame = nextState == FLUSH;
   assign take = state == DRAIN && out_start && !abort;
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state <= IDLE;
         holdCnt <= HW'(1);
         data_reg <= '0;
         byte_count <= '0;
         error_code <= '0;
      end else begin
         state <= nextState;
         holdCnt <= state == HOLD ? holdCnt + 1'b1 : HW'(1);
         if (newFrame) begin
            data_reg <= '0;
            byte_count <= '0;
            error_code <= '0;
         end else begin
            error_code <= nextCode;
            if (take) begin
               data_reg <= out_data;
               byte_count <= &byte_count ? byte_count : byte_count + 1'b1;
            end
         end
      end
   assign com_enable = state == RECV;
   assign fifo_reset = state == FLUSH;
   assign fifo_to_out_en = state == DRAIN || state == HOLD;
   assign out_finish = state == FIN;
   assign busy = state inside {FLUSH, RECV, CHECK, DRAIN, HOLD, FIN};
   assign done = state == DONE;
   assign error = state == ERROR;
endmodule

// File: tb/tb_fifo_pipeline_sequencer.sv
// tb_fifo_pipeline_sequencer: randomized frames against a queue-based FIFO/consumer model.
// Define SEQ_TIMEOUT_EN to build the watchdog variant (TIMEOUT_CYCLES=16).
module tb_fifo_pipeline_sequencer;
   localparam int HOLD = 4;
   localparam int CW = 10;
   localparam int MAXC = (1 << CW) - 1;
`ifdef SEQ_TIMEOUT_EN
   localparam int TO = 16;
`else
   localparam int TO = 65535;
`endif
   logic clk = 0, reset = 1, start = 0, abort = 0, com_finish = 0, fifo_empty = 1, fifo_full = 0;
   logic out_start = 0, out_ack = 0;
   logic [3:0] com_error = 0;
   logic [7:0] out_data = 0;
   logic com_enable, fifo_reset, fifo_to_out_en, out_finish, busy, done, error;
   logic [7:0] data_reg;
   logic [CW-1:0] byte_count;
   logic [3:0] error_code;
   int total = 0, bad = 0, finCount = 0;

   fifo_pipeline_sequencer #(.HOLD_CYCLES(HOLD), .TIMEOUT_CYCLES(TO), .CNT_W(CW)) dut (
      .clk(clk), .reset(reset), .start(start), .abort(abort), .com_finish(com_finish),
      .com_error(com_error), .fifo_empty(fifo_empty), .fifo_full(fifo_full),
      .out_start(out_start), .out_data(out_data), .out_ack(out_ack),
      .com_enable(com_enable), .fifo_reset(fifo_reset), .fifo_to_out_en(fifo_to_out_en),
      .out_finish(out_finish), .data_reg(data_reg), .byte_count(byte_count),
      .busy(busy), .done(done), .error(error), .error_code(error_code));

   always #5 clk = ~clk;
   always @(negedge clk) if (out_finish === 1'b1) finCount++;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1;
      repeat (2) cyc();
      total++;
      if ({com_enable, fifo_reset, fifo_to_out_en, out_finish, busy, done, error} !== 7'b0 ||
          data_reg !== 8'h00 || byte_count !== '0 || error_code !== 4'h0)
         begin bad++; $display("FAIL reset: outputs en=%0b rst=%0b oe=%0b fin=%0b busy=%0b done=%0b err=%0b data=%h cnt=%0d code=%h, required all 0",
            com_enable, fifo_reset, fifo_to_out_en, out_finish, busy, done, error, data_reg, byte_count, error_code); end
      reset = 0;
      cyc();
   endtask

   // Enter RECV from any resting state: start, FLUSH cycle, then RECV
   task automatic enterRecv(input bit emptyFifo);
      start = 1;
      cyc();
      start = 0;
      total++;
      if (fifo_reset !== 1'b1 || busy !== 1'b1 || error !== 1'b0 || error_code !== 4'h0 || byte_count !== '0)
         begin bad++; $display("FAIL flush: fifo_reset=%0b busy=%0b error=%0b code=%h cnt=%0d, required 1 1 0 0 0", fifo_reset, busy, error, error_code, byte_count); end
      fifo_empty = emptyFifo;
      cyc();
      total++;
      if (com_enable !== 1'b1 || fifo_reset !== 1'b0)
         begin bad++; $display("FAIL recv: com_enable=%0b fifo_reset=%0b, required 1 0", com_enable, fifo_reset); end
   endtask

   task automatic test_frame(input int n, input bit ackMode, input bit junk);
      byte unsigned q[$];
      logic [7:0] last;
      int expCnt, lat, fin0;
      bit ack;
      for (int i = 0; i < n; i++) q.push_back(8'($urandom));
      last = 8'h00;
      fin0 = finCount;
      enterRecv(n == 0);
      repeat ($urandom_range(3)) cyc();
      com_finish = 1;
      cyc();
      com_finish = 0;
      total++;
      if (com_enable !== 1'b0 || busy !== 1'b1)
         begin bad++; $display("FAIL check: com_enable=%0b busy=%0b, required 0 1", com_enable, busy); end
      cyc();
      for (int i = 0; i < n; i++) begin
         repeat ($urandom_range(2)) cyc();
         total++;
         if (fifo_to_out_en !== 1'b1 || out_finish !== 1'b0)
            begin bad++; $display("FAIL drain: fifo_to_out_en=%0b out_finish=%0b, required 1 0", fifo_to_out_en, out_finish); end
         out_start = 1;
         out_data = q[0];
         cyc();
         out_start = 0;
         out_data = 8'($urandom);
         last = q.pop_front();
         fifo_empty = (q.size() == 0);
         expCnt = (i + 1 > MAXC) ? MAXC : i + 1;
         total++;
         if (data_reg !== last || byte_count !== expCnt)
            begin bad++; $display("FAIL latch: data_reg=%h byte_count=%0d, required %h %0d", data_reg, byte_count, last, expCnt); end
         ack = ackMode && ($urandom_range(1) == 1);
         if (ack) out_ack = 1;
         else if (junk) begin out_start = 1; out_data = ~last; end
         lat = 1;
         while (out_finish !== 1'b1 && lat < HOLD + 20) begin
            cyc();
            out_ack = 0;
            out_start = 0;
            lat++;
         end
         total++;
         if (lat !== (ack ? 2 : HOLD + 1))
            begin bad++; $display("FAIL latency: out_start->out_finish=%0d cycles, required %0d", lat, ack ? 2 : HOLD + 1); end
         total++;
         if (data_reg !== last || byte_count !== expCnt)
            begin bad++; $display("FAIL hold_ignore: data_reg=%h byte_count=%0d, required %h %0d", data_reg, byte_count, last, expCnt); end
         cyc();
         total++;
         if (out_finish !== 1'b0 || fifo_to_out_en !== 1'b1)
            begin bad++; $display("FAIL fin_pulse: out_finish=%0b fifo_to_out_en=%0b, required 0 1", out_finish, fifo_to_out_en); end
      end
      if (n > 0) cyc();
      expCnt = n > MAXC ? MAXC : n;
      total++;
      if (done !== 1'b1 || busy !== 1'b0 || fifo_to_out_en !== 1'b0 || byte_count !== expCnt || data_reg !== last || finCount - fin0 !== n)
         begin bad++; $display("FAIL done: done=%0b busy=%0b oe=%0b cnt=%0d data=%h finishes=%0d, required 1 0 0 %0d %h %0d",
            done, busy, fifo_to_out_en, byte_count, data_reg, finCount - fin0, expCnt, last, n); end
   endtask

   task automatic test_com_error(input logic [3:0] code);
      enterRecv(1'b0);
      com_error = code;
      com_finish = 1;
      cyc();
      com_error = 0;
      total++;
      if (error !== 1'b1 || error_code !== code || com_enable !== 1'b0 || busy !== 1'b0)
         begin bad++; $display("FAIL com_error: error=%0b code=%h com_enable=%0b busy=%0b, required 1 %h 0 0", error, error_code, com_enable, busy, code); end
      cyc();
      com_finish = 0;
      total++;
      if (error !== 1'b1 || com_enable !== 1'b0)
         begin bad++; $display("FAIL error_stick: error=%0b com_enable=%0b, required 1 0", error, com_enable); end
      abort = 1;
      cyc();
      abort = 0;
      total++;
      if (error !== 1'b0 || busy !== 1'b0 || done !== 1'b0)
         begin bad++; $display("FAIL error_abort: error=%0b busy=%0b done=%0b, required 0 0 0", error, busy, done); end
   endtask

   task automatic test_fifo_full();
      enterRecv(1'b1);
      fifo_full = 1;
      com_finish = 1;
      cyc();
      com_finish = 0;
      total++;
      if (error !== 1'b0 || busy !== 1'b1 || com_enable !== 1'b0)
         begin bad++; $display("FAIL full_finish: error=%0b busy=%0b com_enable=%0b, required 0 1 0", error, busy, com_enable); end
      fifo_full = 0;
      cyc();
      enterRecv(1'b0);
      fifo_full = 1;
      cyc();
      fifo_full = 0;
      total++;
      if (error !== 1'b1 || error_code !== 4'hF || com_enable !== 1'b0)
         begin bad++; $display("FAIL full: error=%0b code=%h com_enable=%0b, required 1 f 0", error, error_code, com_enable); end
      enterRecv(1'b0);
      abort = 1;
      cyc();
      abort = 0;
   endtask

   task automatic test_abort();
      enterRecv(1'b0);
      com_finish = 1;
      cyc();
      com_finish = 0;
      cyc();
      out_start = 1;
      out_data = 8'hA5;
      abort = 1;
      cyc();
      out_start = 0;
      abort = 0;
      total++;
      if (byte_count !== '0 || data_reg !== 8'h00 || fifo_to_out_en !== 1'b0 || busy !== 1'b0 || done !== 1'b0)
         begin bad++; $display("FAIL abort: cnt=%0d data=%h oe=%0b busy=%0b done=%0b, required 0 00 0 0 0", byte_count, data_reg, fifo_to_out_en, busy, done); end
      repeat (3) cyc();
      total++;
      if (busy !== 1'b0 || fifo_reset !== 1'b0)
         begin bad++; $display("FAIL abort_idle: busy=%0b fifo_reset=%0b, required 0 0", busy, fifo_reset); end
   endtask

   task automatic test_reset_mid();
      enterRecv(1'b0);
      com_finish = 1;
      cyc();
      com_finish = 0;
      cyc();
      out_start = 1;
      out_data = 8'h5A;
      cyc();
      out_start = 0;
      #2 reset = 1;
      #1;
      total++;
      if ({com_enable, fifo_reset, fifo_to_out_en, out_finish, busy, done, error} !== 7'b0 || data_reg !== 8'h00 || byte_count !== '0)
         begin bad++; $display("FAIL reset_mid: oe=%0b busy=%0b data=%h cnt=%0d, required all 0", fifo_to_out_en, busy, data_reg, byte_count); end
      cyc();
      reset = 0;
      fifo_empty = 1;
      repeat (3) cyc();
      total++;
      if (busy !== 1'b0 || done !== 1'b0 || fifo_to_out_en !== 1'b0)
         begin bad++; $display("FAIL reset_idle: busy=%0b done=%0b oe=%0b, required 0 0 0", busy, done, fifo_to_out_en); end
   endtask

   task automatic test_timeout();
      enterRecv(1'b0);
`ifdef SEQ_TIMEOUT_EN
      repeat (TO - 1) cyc();
      total++;
      if (com_enable !== 1'b1 || error !== 1'b0)
         begin bad++; $display("FAIL timeout_early: com_enable=%0b error=%0b, required 1 0", com_enable, error); end
      cyc();
      total++;
      if (error !== 1'b1 || error_code !== 4'hE)
         begin bad++; $display("FAIL timeout: error=%0b code=%h, required 1 e", error, error_code); end
`else
      repeat (200) cyc();
      total++;
      if (com_enable !== 1'b1 || error !== 1'b0)
         begin bad++; $display("FAIL no_timeout: com_enable=%0b error=%0b, required 1 0", com_enable, error); end
`endif
      abort = 1;
      cyc();
      abort = 0;
   endtask

   initial begin
      test_reset();
      test_frame(0, 1'b0, 1'b0);
      test_frame(3, 1'b0, 1'b1);
      for (int k = 0; k < 6; k++) test_frame($urandom_range(1, 6), $urandom_range(1) == 1, $urandom_range(1) == 1);
      test_com_error(4'h2);
      test_com_error(4'($urandom_range(1, 15)));
      test_fifo_full();
      test_abort();
      test_reset_mid();
      test_timeout();
      test_frame(MAXC + 6, 1'b1, 1'b0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
